// File: rtl/imm_prefix_seq_pkg.sv
// Shared constants and state encoding for the immediate/prefix sequencer.
package imm_prefix_seq_pkg;

  localparam int IMM_W    = 16;
  localparam int SHORT_W  = 4;
  localparam int PREFIX_W = 12;

  localparam logic [3:0] PREFIX_OP = 4'hF;
  localparam logic [3:0] ZEXT_OP   = 4'hE;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

endpackage

// File: rtl/sign_ext_4_16.sv
// Combinational sign extension of a short immediate to the full immediate width.
module sign_ext_4_16
  import imm_prefix_seq_pkg::*;
(
  input  logic [SHORT_W-1:0] i_short,
  output logic [IMM_W-1:0]   o_imm
);

  assign o_imm = {{(IMM_W-SHORT_W){i_short[SHORT_W-1]}}, i_short};

endmodule

// File: rtl/imm_prefix_seq.sv
// Forms 16-bit immediates from short fields or PREFIX payloads; one registered output entry.
// Optional IMM_PREFIX_ZEXT_EN: ZEXT_OP zero-extends its short immediate when no prefix is pending.
module imm_prefix_seq
  import imm_prefix_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_op,
  output logic [15:0] out_imm,
  output logic        out_prefixed,
  output logic        err_dbl_prefix
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PREFIX_W-1:0] r_prefix;
  logic [PREFIX_W-1:0] w_prefix_nxt;
  logic                r_out_valid;
  logic                w_out_valid_nxt;
  logic [3:0]          r_out_op;
  logic [3:0]          w_out_op_nxt;
  logic [IMM_W-1:0]    r_out_imm;
  logic [IMM_W-1:0]    w_out_imm_nxt;
  logic                r_out_prefixed;
  logic                w_out_prefixed_nxt;
  logic                r_err;
  logic                w_err_nxt;

  logic [3:0]          w_op;
  logic                w_is_prefix;
  logic                w_in_ready;
  logic                w_accept;
  logic [IMM_W-1:0]    w_sext;
  logic [IMM_W-1:0]    w_short_imm;

  assign w_op        = in_instr[15:12];
  assign w_is_prefix = (w_op == PREFIX_OP);
  assign w_in_ready  = (!r_out_valid || out_ready) && !flush;
  assign w_accept    = in_valid && w_in_ready;

  sign_ext_4_16 u_sext (
    .i_short (in_instr[SHORT_W-1:0]),
    .o_imm   (w_sext)
  );

`ifdef IMM_PREFIX_ZEXT_EN
  assign w_short_imm = (w_op == ZEXT_OP) ? {{(IMM_W-SHORT_W){1'b0}}, in_instr[SHORT_W-1:0]} : w_sext;
`else
  assign w_short_imm = w_sext;
`endif

  always_comb begin
    w_state_nxt        = r_state;
    w_prefix_nxt       = r_prefix;
    w_out_valid_nxt    = r_out_valid && !out_ready;
    w_out_op_nxt       = r_out_op;
    w_out_imm_nxt      = r_out_imm;
    w_out_prefixed_nxt = r_out_prefixed;
    w_err_nxt          = r_err;
    if (flush) begin
      // Redirect drops both the pending prefix and the output entry; the sticky error survives.
      w_state_nxt     = IDLE;
      w_out_valid_nxt = 1'b0;
    end else if (w_accept) begin
      if (w_is_prefix) begin
        w_prefix_nxt = in_instr[PREFIX_W-1:0];
        w_state_nxt  = HELD;
        if (r_state == HELD) begin
          w_err_nxt = 1'b1;
        end
      end else begin
        w_state_nxt     = IDLE;
        w_out_valid_nxt = 1'b1;
        w_out_op_nxt    = w_op;
        if (r_state == HELD) begin
          w_out_imm_nxt      = {r_prefix, in_instr[SHORT_W-1:0]};
          w_out_prefixed_nxt = 1'b1;
        end else begin
          w_out_imm_nxt      = w_short_imm;
          w_out_prefixed_nxt = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prefix       <= '0;
      r_out_valid    <= 1'b0;
      r_out_op       <= '0;
      r_out_imm      <= '0;
      r_out_prefixed <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_prefix       <= w_prefix_nxt;
      r_out_valid    <= w_out_valid_nxt;
      r_out_op       <= w_out_op_nxt;
      r_out_imm      <= w_out_imm_nxt;
      r_out_prefixed <= w_out_prefixed_nxt;
      r_err          <= w_err_nxt;
    end
  end

  assign in_ready       = w_in_ready;
  assign out_valid      = r_out_valid;
  assign out_op         = r_out_op;
  assign out_imm        = r_out_imm;
  assign out_prefixed   = r_out_prefixed;
  assign err_dbl_prefix = r_err;

endmodule

// File: tb/tb_imm_prefix_seq.sv
// Scoreboard bench for imm_prefix_seq: expected entries queued on accept, checked on output handshake.
module tb_imm_prefix_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [15:0] out_imm;
  logic        out_prefixed;
  logic        err_dbl_prefix;

  imm_prefix_seq dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_op         (out_op),
    .out_imm        (out_imm),
    .out_prefixed   (out_prefixed),
    .err_dbl_prefix (err_dbl_prefix)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] imm;
    logic        pf;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_pop;
  exp_t        e_push;
  int          n_vec = 0;
  int          n_miscmp = 0;
  logic        m_held = 1'b0;
  logic [11:0] m_pfx = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_imm(input logic [15:0] ins);
    if (m_held) return {m_pfx, ins[3:0]};
`ifdef IMM_PREFIX_ZEXT_EN
    if (ins[15:12] == 4'hE) return {12'h000, ins[3:0]};
`endif
    return {{12{ins[3]}}, ins[3:0]};
  endfunction

  // Output handshakes are popped before this cycle's accept is pushed.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", 32'd1, 32'd0);
        end else begin
          e_pop = sb.pop_front();
          chk("sb_op", {28'd0, out_op}, {28'd0, e_pop.op});
          chk("sb_imm", {16'd0, out_imm}, {16'd0, e_pop.imm});
          chk("sb_prefixed", {31'd0, out_prefixed}, {31'd0, e_pop.pf});
        end
      end
      if (flush) begin
        sb.delete();
        m_held = 1'b0;
      end else if (in_valid && in_ready) begin
        if (in_instr[15:12] == 4'hF) begin
          m_held = 1'b1;
          m_pfx  = in_instr[11:0];
        end else begin
          e_push.op  = in_instr[15:12];
          e_push.imm = model_imm(in_instr);
          e_push.pf  = m_held;
          sb.push_back(e_push);
          m_held = 1'b0;
        end
      end
    end
  end

  always @(posedge rst) begin
    sb.delete();
    m_held = 1'b0;
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call only just after a rising edge; returns just after the accepting edge with in_valid low.
  task automatic send(input logic [15:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b1;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_op", {28'd0, out_op}, 32'd0);
    chk("rst_out_imm", {16'd0, out_imm}, 32'd0);
    chk("rst_out_prefixed", {31'd0, out_prefixed}, 32'd0);
    chk("rst_err", {31'd0, err_dbl_prefix}, 32'd0);
    #1 rst = 1'b0;

    // Short immediate, positive and negative
    sync();
    send(16'h1007);
    @(negedge clk);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_op", {28'd0, out_op}, 32'h1);
    chk("t1_imm", {16'd0, out_imm}, 32'h0007);
    sync();
    send(16'h200C);
    @(negedge clk);
    chk("t2_imm", {16'd0, out_imm}, 32'hFFFC);

    // Prefix then consumer
    sync();
    send(16'hFABC);
    @(negedge clk);
    chk("t3_no_out_after_prefix", {31'd0, out_valid}, 32'd0);
    sync();
    send(16'h3005);
    @(negedge clk);
    chk("t3_imm", {16'd0, out_imm}, 32'hABC5);
    chk("t3_prefixed", {31'd0, out_prefixed}, 32'd1);
    chk("t3_op", {28'd0, out_op}, 32'h3);

    // Backpressure with a waiting instruction
    sync();
    send(16'h1003);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 16'h1004;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_imm_stable", {16'd0, out_imm}, 32'h0003);
    end
    sync();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    sync();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_no_bubble", {31'd0, out_valid}, 32'd1);
    chk("bp_next_imm", {16'd0, out_imm}, 32'h0004);

    // Double prefix, back-to-back
    sync();
    send(16'hF111);
    send(16'hF222);
    send(16'h1009);
    @(negedge clk);
    chk("dbl_err", {31'd0, err_dbl_prefix}, 32'd1);
    chk("dbl_imm", {16'd0, out_imm}, 32'h2229);
    repeat (3) @(negedge clk);
    chk("dbl_err_sticky", {31'd0, err_dbl_prefix}, 32'd1);

    // Flush drops a pending prefix and beats a concurrent accept
    sync();
    send(16'hF123);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 16'h1111;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    sync();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_out", {31'd0, out_valid}, 32'd0);
    sync();
    send(16'h1008);
    @(negedge clk);
    chk("flush_imm", {16'd0, out_imm}, 32'hFFF8);
    chk("flush_prefixed", {31'd0, out_prefixed}, 32'd0);
    chk("flush_err_kept", {31'd0, err_dbl_prefix}, 32'd1);

    // Flush discards a stalled output entry
    sync();
    out_ready = 1'b0;
    send(16'h100A);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_entry_held", {31'd0, out_valid}, 32'd1);
    sync();
    flush     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_entry_gone", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while HELD
    sync();
    send(16'hF0AA);
    send(16'hFBBB);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_op", {28'd0, out_op}, 32'd0);
    chk("arst_out_imm", {16'd0, out_imm}, 32'd0);
    chk("arst_out_prefixed", {31'd0, out_prefixed}, 32'd0);
    chk("arst_err", {31'd0, err_dbl_prefix}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    sync();
    send(16'h1006);
    @(negedge clk);
    chk("arst_prefix_lost", {16'd0, out_imm}, 32'h0006);
    chk("arst_prefixed", {31'd0, out_prefixed}, 32'd0);

    // ZEXT opcode in IDLE
    sync();
    send(16'hE00F);
    @(negedge clk);
`ifdef IMM_PREFIX_ZEXT_EN
    chk("zext_imm", {16'd0, out_imm}, 32'h000F);
`else
    chk("zext_off_imm", {16'd0, out_imm}, 32'hFFFF);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
